// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: boot / run / drain / halt sequencer and hazard controller
// for the 5-stage core. Hazard strobes are combinational from state and
// inputs; only the sequencing state, cycle counter and stall counter are flops.
module pipeline_ctrl #(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 2,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic        pcSelect,
  output logic [31:0] startAddress,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        halted,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0]  BOOT_CNT_INIT  = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0]  DRAIN_CNT_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [15:0] STALL_MAX      = 16'hFFFF;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        load_use_s;

  // The boot PC value is a constant; the PC mux only looks at it when pcSelect is high.
  assign startAddress = BOOT_ADDR;
  assign stall_count  = stall_count_q;

  // Load-use hazard: a load in EX writes a register the ID instruction reads (r0 never hazards).
  always_comb begin
    load_use_s = 1'b0;
    if (ex_mem_read && (ex_rt != 5'd0)) begin
      load_use_s = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next-state, counters and per-state strobes; branch beats load-use beats halt in RUN.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_count_d = stall_count_q;
    pcSelect      = 1'b0;
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    pc_redirect   = 1'b0;
    redirect_addr = 32'h0000_0000;
    halted        = 1'b0;
    case (state_q)
      ST_BOOT: begin
        pcSelect    = 1'b1;
        pc_write    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_redirect   = 1'b1;
          redirect_addr = branch_target;
          ifid_flush    = 1'b1;
          idex_bubble   = 1'b1;
          pc_write      = 1'b1;
        end else if (load_use_s) begin
          idex_bubble = 1'b1;
          if (stall_count_q != STALL_MAX) begin
            stall_count_d = stall_count_q + 16'd1;
          end else begin
            stall_count_d = stall_count_q;
          end
        end else if (halt_req) begin
          ifid_flush = 1'b1;
          state_d    = ST_DRAIN;
          cnt_d      = DRAIN_CNT_INIT;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      ST_DRAIN: begin
        ifid_flush = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (restart) begin
          state_d       = ST_BOOT;
          cnt_d         = BOOT_CNT_INIT;
          stall_count_d = 16'h0000;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d       = ST_BOOT;
        cnt_d         = BOOT_CNT_INIT;
        stall_count_d = 16'h0000;
      end
    endcase
  end

  // Sequencing state registers; reset parks the controller at the start of BOOT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      cnt_q         <= BOOT_CNT_INIT;
      stall_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plus randomized bench. A phase-countdown model
// predicts every output each cycle; directed steps pin literal values.
module tb_pipeline_ctrl;

  localparam logic [31:0] BOOT_ADDR    = 32'h0000_0000;
  localparam int          BOOT_CYCLES  = 2;
  localparam int          DRAIN_CYCLES = 4;

  logic        clk, rst, restart;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, branch_taken, halt_req;
  logic [31:0] branch_target;
  logic        pcSelect, pc_write, ifid_write, ifid_flush, idex_bubble, pc_redirect, halted;
  logic [31:0] startAddress, redirect_addr;
  logic [15:0] stall_count;

  int n_total = 0;
  int n_pass  = 0;
  bit check_en = 1'b0;

  pipeline_ctrl #(
    .BOOT_ADDR(BOOT_ADDR), .BOOT_CYCLES(BOOT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .pcSelect(pcSelect), .startAddress(startAddress), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pc_redirect(pc_redirect), .redirect_addr(redirect_addr),
    .halted(halted), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phases are tracked as "cycles remaining" counts rather than a state code.
  int m_boot_left  = BOOT_CYCLES;
  int m_drain_left = 0;
  bit m_parked     = 1'b0;
  int m_stalls     = 0;

  bit          m_lu;
  bit          e_pcsel, e_pcw, e_ifw, e_flush, e_bub, e_redir, e_halted;
  logic [31:0] e_raddr;

  // Expected strobes from the model phase and the current inputs.
  always_comb begin
    e_pcsel = 1'b0; e_pcw = 1'b0; e_ifw = 1'b0; e_flush = 1'b0;
    e_bub = 1'b0; e_redir = 1'b0; e_halted = 1'b0; e_raddr = 32'h0;
    m_lu = ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (m_boot_left > 0) begin
      e_pcsel = 1'b1; e_pcw = 1'b1; e_flush = 1'b1; e_bub = 1'b1;
    end else if (m_drain_left > 0) begin
      e_flush = 1'b1;
    end else if (m_parked) begin
      e_halted = 1'b1;
    end else if (branch_taken) begin
      e_redir = 1'b1; e_raddr = branch_target; e_flush = 1'b1; e_bub = 1'b1; e_pcw = 1'b1;
    end else if (m_lu) begin
      e_bub = 1'b1;
    end else if (halt_req) begin
      e_flush = 1'b1;
    end else begin
      e_pcw = 1'b1; e_ifw = 1'b1;
    end
  end

  // Model phase advance at each edge; reset is asynchronous as in the core.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot_left  <= BOOT_CYCLES;
      m_drain_left <= 0;
      m_parked     <= 1'b0;
      m_stalls     <= 0;
    end else if (m_boot_left > 0) begin
      m_boot_left <= m_boot_left - 1;
    end else if (m_drain_left > 0) begin
      m_drain_left <= m_drain_left - 1;
      if (m_drain_left == 1) m_parked <= 1'b1;
    end else if (m_parked) begin
      if (restart) begin
        m_parked    <= 1'b0;
        m_boot_left <= BOOT_CYCLES;
        m_stalls    <= 0;
      end
    end else if (branch_taken) begin
      m_stalls <= m_stalls;
    end else if (m_lu) begin
      m_stalls <= (m_stalls < 65535) ? m_stalls + 1 : 65535;
    end else if (halt_req) begin
      m_drain_left <= DRAIN_CYCLES;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare process: every output against the model, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_pcSelect",     {31'd0, pcSelect},    {31'd0, e_pcsel});
      chk("m_startAddress", startAddress,         BOOT_ADDR);
      chk("m_pc_write",     {31'd0, pc_write},    {31'd0, e_pcw});
      chk("m_ifid_write",   {31'd0, ifid_write},  {31'd0, e_ifw});
      chk("m_ifid_flush",   {31'd0, ifid_flush},  {31'd0, e_flush});
      chk("m_idex_bubble",  {31'd0, idex_bubble}, {31'd0, e_bub});
      chk("m_pc_redirect",  {31'd0, pc_redirect}, {31'd0, e_redir});
      chk("m_redirect_addr", redirect_addr,       e_raddr);
      chk("m_halted",       {31'd0, halted},      {31'd0, e_halted});
      chk("m_stall_count",  {16'd0, stall_count}, m_stalls[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    restart = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; branch_taken = 1'b0;
    branch_target = 32'h0; halt_req = 1'b0;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic rand_inputs();
    restart       = ($urandom_range(0, 5) == 0);
    id_rs         = 5'($urandom_range(0, 3));
    id_rt         = 5'($urandom_range(0, 3));
    id_uses_rt    = 1'($urandom_range(0, 1));
    ex_mem_read   = 1'($urandom_range(0, 1));
    ex_rt         = 5'($urandom_range(0, 3));
    branch_taken  = ($urandom_range(0, 7) == 0);
    branch_target = $urandom;
    halt_req      = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    check_en = 1'b1;
    #2;
    settle();
    chk("reset_pcSelect", {31'd0, pcSelect}, 32'd1);
    chk("reset_ifid_write", {31'd0, ifid_write}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // BOOT for two cycles, then RUN
    settle();
    chk("boot1_pcSelect", {31'd0, pcSelect}, 32'd1);
    chk("boot1_startAddress", startAddress, 32'h0);
    tick(); settle();
    chk("boot2_pcSelect", {31'd0, pcSelect}, 32'd1);
    tick(); settle();
    chk("run_pcSelect", {31'd0, pcSelect}, 32'd0);
    chk("run_pc_write", {31'd0, pc_write}, 32'd1);
    chk("run_ifid_write", {31'd0, ifid_write}, 32'd1);

    // load-use stall on r5
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    settle();
    chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
    chk("lu_ifid_write", {31'd0, ifid_write}, 32'd0);
    chk("lu_idex_bubble", {31'd0, idex_bubble}, 32'd1);
    chk("lu_stall_before", {16'd0, stall_count}, 32'd0);
    tick(); idle(); settle();
    chk("lu_stall_after", {16'd0, stall_count}, 32'd1);

    // load to r0 never stalls
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    settle();
    chk("lu_r0_pc_write", {31'd0, pc_write}, 32'd1);
    chk("lu_r0_ifid_write", {31'd0, ifid_write}, 32'd1);

    // branch wins over load-use
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    branch_taken = 1'b1; branch_target = 32'h40;
    settle();
    chk("br_pc_redirect", {31'd0, pc_redirect}, 32'd1);
    chk("br_redirect_addr", redirect_addr, 32'h40);
    chk("br_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    chk("br_idex_bubble", {31'd0, idex_bubble}, 32'd1);
    tick(); idle(); settle();
    chk("br_stall_unchanged", {16'd0, stall_count}, 32'd1);

    // restart in RUN is ignored
    restart = 1'b1;
    tick(); idle(); settle();
    chk("rst_in_run_pcSelect", {31'd0, pcSelect}, 32'd0);
    chk("rst_in_run_stalls", {16'd0, stall_count}, 32'd1);

    // halt: one RUN cycle, four DRAIN cycles ignoring branches, then HALT
    halt_req = 1'b1;
    settle();
    chk("halt_pc_write", {31'd0, pc_write}, 32'd0);
    chk("halt_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      branch_taken = 1'b1; branch_target = 32'h123;
      settle();
      chk("drain_pc_write", {31'd0, pc_write}, 32'd0);
      chk("drain_pc_redirect", {31'd0, pc_redirect}, 32'd0);
      chk("drain_halted", {31'd0, halted}, 32'd0);
      tick();
    end
    idle(); settle();
    chk("halted_high", {31'd0, halted}, 32'd1);

    // restart from HALT: two BOOT cycles with cleared counter, then RUN
    restart = 1'b1;
    tick(); idle(); settle();
    chk("restart_boot1", {31'd0, pcSelect}, 32'd1);
    chk("restart_stalls", {16'd0, stall_count}, 32'd0);
    tick(); settle();
    chk("restart_boot2", {31'd0, pcSelect}, 32'd1);
    tick(); settle();
    chk("restart_run", {31'd0, pcSelect}, 32'd0);
    chk("restart_run_pcw", {31'd0, pc_write}, 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      rand_inputs();
    end

    // get back to a clean RUN via reset, then saturate the stall counter
    tick(); idle();
    rst = 1'b1;
    tick(); rst = 1'b0;
    repeat (3) tick();
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    repeat (65540) tick();
    settle();
    chk("sat_stall_count", {16'd0, stall_count}, 32'h0000_FFFF);
    repeat (5) tick();
    settle();
    chk("sat_hold", {16'd0, stall_count}, 32'h0000_FFFF);

    // async reset mid-DRAIN
    tick(); idle(); halt_req = 1'b1;
    tick(); idle();
    tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_pcSelect", {31'd0, pcSelect}, 32'd1);
    chk("arst_pc_write", {31'd0, pc_write}, 32'd1);
    chk("arst_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    chk("arst_idex_bubble", {31'd0, idex_bubble}, 32'd1);
    chk("arst_ifid_write", {31'd0, ifid_write}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_stall_count", {16'd0, stall_count}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < 500; i++) begin
      tick();
      rand_inputs();
    end
    tick();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
